// File: rtl/clock_switch_pkg.sv
// Shared types and width helpers for the N-way clock switch sequencer.
package clock_switch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DISABLE = 2'd1,
      ST_DEAD    = 2'd2,
      ST_ENABLE  = 2'd3
   } state_e;

   // Bits needed to hold any value in 0..max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus of independent asynchronous status bits.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/clock_switch_ctrl.sv
// Break-before-make sequencer driving the per-source clock gate enables,
// with dead time, acknowledge timeouts and sticky error reporting.
module clock_switch_ctrl
   import clock_switch_pkg::*;
#(
   parameter int NUM_SRC     = 4,
   parameter int SEL_W       = $clog2(NUM_SRC),
   parameter int DEAD_CYCLES = 4,
   parameter int ACK_TIMEOUT = 255,
   parameter int DEFAULT_SRC = 0
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               SEL_REQ,
   input  logic [SEL_W-1:0]   SEL_IDX,
   output logic               SEL_READY,
   output logic [NUM_SRC-1:0] SRC_EN,
   input  logic [NUM_SRC-1:0] SRC_ACK_ASYNC,
   output logic [SEL_W-1:0]   CUR_SRC,
   output logic               DONE,
   output logic               ERR_TIMEOUT,
   output logic               ERR_BADIDX,
   input  logic               ERR_CLR
);

   localparam int ACK_W  = cnt_width(ACK_TIMEOUT);
   localparam int DEAD_W = cnt_width(DEAD_CYCLES);

   // The dead counter holds the number of DEAD cycles still to come after the
   // current one. After a break, the cycle in which ack_s confirms the old gate
   // stopped already counts as the first dead cycle; after reset nothing is
   // confirmed, so the full dead time is spent in DEAD.
   localparam logic [DEAD_W-1:0] DEAD_RST_LOAD = DEAD_W'(DEAD_CYCLES - 1);
   localparam logic [DEAD_W-1:0] DEAD_BRK_LOAD = DEAD_W'((DEAD_CYCLES > 1) ? DEAD_CYCLES - 2 : 0);
   localparam logic [ACK_W-1:0]  TO_LAST       = ACK_W'(ACK_TIMEOUT - 1);
   localparam logic [ACK_W-1:0]  TO_MAX        = ACK_W'(ACK_TIMEOUT);
   localparam logic [SEL_W-1:0]  DEF_IDX       = SEL_W'(DEFAULT_SRC);

   logic [NUM_SRC-1:0] ack_s;
   logic               bad_idx;

   state_e             state_q,    state_d;
   logic [SEL_W-1:0]   target_q,   target_d;
   logic [SEL_W-1:0]   cur_q,      cur_d;
   logic [NUM_SRC-1:0] src_en_q,   src_en_d;
   logic [DEAD_W-1:0]  dead_cnt_q, dead_cnt_d;
   logic [ACK_W-1:0]   to_cnt_q,   to_cnt_d;
   logic               done_q,     done_d;
   logic               boot_q,     boot_d;
   logic               err_to_q,   err_to_d;
   logic               err_bad_q,  err_bad_d;
   logic               set_to;
   logic               set_bad;

   sync_2ff #(
      .WIDTH (NUM_SRC)
   ) u_ack_sync (
      .clk_i (CLK),
      .rst_i (RST),
      .d_i   (SRC_ACK_ASYNC),
      .q_o   (ack_s)
   );

   assign bad_idx = ({1'b0, SEL_IDX} >= (SEL_W + 1)'(NUM_SRC));

   always_comb begin
      state_d    = state_q;
      target_d   = target_q;
      cur_d      = cur_q;
      src_en_d   = src_en_q;
      dead_cnt_d = dead_cnt_q;
      to_cnt_d   = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
      done_d     = 1'b0;
      boot_d     = boot_q;
      set_to     = 1'b0;
      set_bad    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (SEL_REQ) begin
               if (bad_idx) begin
                  set_bad = 1'b1;
               end else if (SEL_IDX == cur_q) begin
                  done_d = 1'b1;
               end else begin
                  target_d = SEL_IDX;
                  src_en_d = '0;
                  to_cnt_d = '0;
                  state_d  = ST_DISABLE;
               end
            end
         end
         ST_DISABLE: begin
            // A dead old source must not wedge the switch: give up and move on.
            if (!ack_s[cur_q] || (to_cnt_q == TO_LAST)) begin
               set_to     = ack_s[cur_q];
               dead_cnt_d = DEAD_BRK_LOAD;
               state_d    = ST_DEAD;
            end
         end
         ST_DEAD: begin
            if (dead_cnt_q == '0) begin
               src_en_d           = '0;
               src_en_d[target_q] = 1'b1;
               to_cnt_d           = '0;
               state_d            = ST_ENABLE;
            end else begin
               dead_cnt_d = dead_cnt_q - 1'b1;
            end
         end
         ST_ENABLE: begin
            // On timeout the enable is left asserted; the gate may still start.
            if (ack_s[target_q] || (to_cnt_q == TO_LAST)) begin
               set_to  = !ack_s[target_q];
               cur_d   = target_q;
               done_d  = !boot_q;
               boot_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_DEAD;
      endcase

      err_to_d  = set_to  | (err_to_q  & ~ERR_CLR);
      err_bad_d = set_bad | (err_bad_q & ~ERR_CLR);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_DEAD;
         target_q   <= DEF_IDX;
         cur_q      <= DEF_IDX;
         src_en_q   <= '0;
         dead_cnt_q <= DEAD_RST_LOAD;
         to_cnt_q   <= '0;
         done_q     <= 1'b0;
         boot_q     <= 1'b1;
         err_to_q   <= 1'b0;
         err_bad_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         target_q   <= target_d;
         cur_q      <= cur_d;
         src_en_q   <= src_en_d;
         dead_cnt_q <= dead_cnt_d;
         to_cnt_q   <= to_cnt_d;
         done_q     <= done_d;
         boot_q     <= boot_d;
         err_to_q   <= err_to_d;
         err_bad_q  <= err_bad_d;
      end
   end

   assign SEL_READY   = (state_q == ST_IDLE);
   assign SRC_EN      = src_en_q;
   assign CUR_SRC     = cur_q;
   assign DONE        = done_q;
   assign ERR_TIMEOUT = err_to_q;
   assign ERR_BADIDX  = err_bad_q;

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// Directed bench: scoreboard of expected DONE pulses plus timed checks of
// enables, errors and reset behaviour on a 4-source and a 3-source instance.
module tb_clock_switch_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       SEL_REQ = 1'b0;
   logic [1:0] SEL_IDX = '0;
   logic       SEL_READY;
   logic [3:0] SRC_EN;
   logic [3:0] SRC_ACK_ASYNC;
   logic [1:0] CUR_SRC;
   logic       DONE;
   logic       ERR_TIMEOUT;
   logic       ERR_BADIDX;
   logic       ERR_CLR = 1'b0;

   logic       sel_req3 = 1'b0;
   logic [1:0] sel_idx3 = '0;
   logic       sel_ready3;
   logic [2:0] src_en3;
   logic [1:0] cur_src3;
   logic       done3;
   logic       err_to3;
   logic       err_bad3;
   logic       err_clr3 = 1'b0;

   // Ideal gates: ack mirrors the enable, with masks to model dead / stuck gates.
   logic [3:0] dead_mask  = '0;
   logic [3:0] stuck_mask = '0;
   assign SRC_ACK_ASYNC = (SRC_EN & ~dead_mask) | stuck_mask;

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   clock_switch_ctrl #(
      .NUM_SRC(4), .DEAD_CYCLES(4), .ACK_TIMEOUT(16), .DEFAULT_SRC(0)
   ) dut (
      .CLK(CLK), .RST(RST), .SEL_REQ(SEL_REQ), .SEL_IDX(SEL_IDX),
      .SEL_READY(SEL_READY), .SRC_EN(SRC_EN), .SRC_ACK_ASYNC(SRC_ACK_ASYNC),
      .CUR_SRC(CUR_SRC), .DONE(DONE), .ERR_TIMEOUT(ERR_TIMEOUT),
      .ERR_BADIDX(ERR_BADIDX), .ERR_CLR(ERR_CLR)
   );

   clock_switch_ctrl #(
      .NUM_SRC(3), .DEAD_CYCLES(4), .ACK_TIMEOUT(16), .DEFAULT_SRC(0)
   ) dut3 (
      .CLK(CLK), .RST(RST), .SEL_REQ(sel_req3), .SEL_IDX(sel_idx3),
      .SEL_READY(sel_ready3), .SRC_EN(src_en3), .SRC_ACK_ASYNC(src_en3),
      .CUR_SRC(cur_src3), .DONE(done3), .ERR_TIMEOUT(err_to3),
      .ERR_BADIDX(err_bad3), .ERR_CLR(err_clr3)
   );

   typedef struct {
      int         cyc;
      logic [1:0] src;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic at_cyc(input int k);
      while (cyc < k) @(negedge CLK);
   endtask

   // Called at a negedge; returns at the negedge of the cycle after acceptance.
   task automatic request(input logic [1:0] idx, input int done_off, output int acc);
      int n;
      SEL_IDX = idx;
      SEL_REQ = 1'b1;
      n = 0;
      while (SEL_READY !== 1'b1 && n < 200) begin
         @(negedge CLK);
         n++;
      end
      if (SEL_READY !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL request_ready: SEL_READY never rose for idx %0d (cycle %0d)", idx, cyc);
         SEL_REQ = 1'b0;
         acc = cyc;
      end else begin
         acc = cyc + 1;
         if (done_off >= 0) exp_q.push_back('{acc + done_off, idx});
         @(negedge CLK);
         SEL_REQ = 1'b0;
         $display("request idx=%0d accepted, first cycle after accept = %0d", idx, acc);
      end
   endtask

   int r;
   int a;

   initial begin
      fork
         begin : monitor
            exp_t e;
            forever begin
               @(negedge CLK);
               #1;
               if (DONE === 1'b1) begin
                  if (exp_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_done: DONE=1 with nothing expected (cycle %0d, CUR_SRC=%0d)", cyc, CUR_SRC);
                  end else begin
                     e = exp_q.pop_front();
                     chk("done_cycle", cyc, e.cyc);
                     chk("done_cur_src", {30'd0, CUR_SRC}, {30'd0, e.src});
                     $display("DONE seen at cycle %0d, CUR_SRC=%0d", cyc, CUR_SRC);
                  end
               end
            end
         end
         begin : watchdog
            #200000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1, "watchdog");
         end
      join_none

      // Reset and power-up sequence on DEFAULT_SRC.
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      r = cyc;
      chk("rst_src_en",    {28'd0, SRC_EN}, 32'h0);
      chk("rst_cur_src",   {30'd0, CUR_SRC}, 32'h0);
      chk("rst_sel_ready", {31'd0, SEL_READY}, 32'h0);
      chk("rst_done",      {31'd0, DONE}, 32'h0);
      chk("rst_err_to",    {31'd0, ERR_TIMEOUT}, 32'h0);
      chk("rst_err_bad",   {31'd0, ERR_BADIDX}, 32'h0);
      at_cyc(r + 3); chk("boot_dead_en",  {28'd0, SRC_EN}, 32'h0);
      at_cyc(r + 4); chk("boot_en0",      {28'd0, SRC_EN}, 32'h1);
      at_cyc(r + 6); chk("boot_not_rdy",  {31'd0, SEL_READY}, 32'h0);
      at_cyc(r + 7); chk("boot_rdy",      {31'd0, SEL_READY}, 32'h1);
      chk("boot_rdy3", {31'd0, sel_ready3}, 32'h1);
      $display("power-up complete at cycle %0d, SRC_EN=%b", cyc, SRC_EN);

      // Normal switch 0 -> 2 with ideal acks.
      request(2'd2, 9, a);
      chk("sw2_break_en",  {28'd0, SRC_EN}, 32'h0);
      chk("sw2_busy",      {31'd0, SEL_READY}, 32'h0);
      at_cyc(a + 5); chk("sw2_dead_en", {28'd0, SRC_EN}, 32'h0);
      at_cyc(a + 6); chk("sw2_make_en", {28'd0, SRC_EN}, 32'h4);
      at_cyc(a + 9); chk("sw2_rdy",     {31'd0, SEL_READY}, 32'h1);
      chk("sw2_cur", {30'd0, CUR_SRC}, 32'h2);

      // Switch 2 -> 1, then request 1 again (no enable change).
      at_cyc(a + 10);
      request(2'd1, 9, a);
      at_cyc(a + 9); chk("sw1_en", {28'd0, SRC_EN}, 32'h2);
      at_cyc(a + 10);
      request(2'd1, 0, a);
      chk("same_en",  {28'd0, SRC_EN}, 32'h2);
      chk("same_rdy", {31'd0, SEL_READY}, 32'h1);
      at_cyc(a + 1);
      chk("same_en_hold", {28'd0, SRC_EN}, 32'h2);
      chk("same_no_disable", {31'd0, SEL_READY}, 32'h1);

      // Old source ack stuck high: DISABLE times out, switch still completes.
      stuck_mask = 4'b0010;
      request(2'd3, 22, a);
      at_cyc(a + 15); chk("stuck_err_pre",  {31'd0, ERR_TIMEOUT}, 32'h0);
      at_cyc(a + 16); chk("stuck_err_set",  {31'd0, ERR_TIMEOUT}, 32'h1);
      at_cyc(a + 18); chk("stuck_dead_en",  {28'd0, SRC_EN}, 32'h0);
      at_cyc(a + 19); chk("stuck_make_en",  {28'd0, SRC_EN}, 32'h8);
      at_cyc(a + 22); chk("stuck_cur",      {30'd0, CUR_SRC}, 32'h3);
      stuck_mask = 4'b0000;
      at_cyc(a + 23); ERR_CLR = 1'b1;
      at_cyc(a + 24); ERR_CLR = 1'b0;
      chk("stuck_err_clr", {31'd0, ERR_TIMEOUT}, 32'h0);

      // New source never acknowledges: ENABLE times out, enable stays on.
      dead_mask = 4'b0001;
      request(2'd0, 22, a);
      at_cyc(a + 21); chk("dead_err_pre", {31'd0, ERR_TIMEOUT}, 32'h0);
      at_cyc(a + 22); chk("dead_err_set", {31'd0, ERR_TIMEOUT}, 32'h1);
      chk("dead_en_kept", {28'd0, SRC_EN}, 32'h1);
      chk("dead_cur",     {30'd0, CUR_SRC}, 32'h0);
      dead_mask = 4'b0000;
      at_cyc(a + 24);

      // Bad index on the 3-source instance, clear, then clear-vs-set collision.
      sel_idx3 = 2'd3;
      sel_req3 = 1'b1;
      chk("bad_rdy_before", {31'd0, sel_ready3}, 32'h1);
      @(negedge CLK);
      sel_req3 = 1'b0;
      chk("bad_flag_set", {31'd0, err_bad3}, 32'h1);
      chk("bad_stay_idle", {31'd0, sel_ready3}, 32'h1);
      chk("bad_en_hold", {29'd0, src_en3}, 32'h1);
      chk("bad_no_done", {31'd0, done3}, 32'h0);
      $display("bad index 3 on 3-source block at cycle %0d, ERR_BADIDX=%0d", cyc, err_bad3);
      err_clr3 = 1'b1;
      @(negedge CLK);
      err_clr3 = 1'b0;
      chk("bad_flag_clr", {31'd0, err_bad3}, 32'h0);
      err_clr3 = 1'b1;
      sel_req3 = 1'b1;
      @(negedge CLK);
      err_clr3 = 1'b0;
      sel_req3 = 1'b0;
      chk("bad_set_wins", {31'd0, err_bad3}, 32'h1);

      // Reset while enabling source 3.
      request(2'd3, -1, a);
      at_cyc(a + 7);
      chk("rst_mid_en3", {28'd0, SRC_EN}, 32'h8);
      RST = 1'b1;
      at_cyc(a + 8);
      RST = 1'b0;
      chk("rst_mid_en_off", {28'd0, SRC_EN}, 32'h0);
      chk("rst_mid_cur",    {30'd0, CUR_SRC}, 32'h0);
      chk("rst_mid_err",    {31'd0, ERR_TIMEOUT}, 32'h0);
      chk("rst_mid_rdy",    {31'd0, SEL_READY}, 32'h0);
      at_cyc(a + 11); chk("rst_mid_dead", {28'd0, SRC_EN}, 32'h0);
      at_cyc(a + 12); chk("rst_mid_en0",  {28'd0, SRC_EN}, 32'h1);
      at_cyc(a + 15); chk("rst_mid_idle", {31'd0, SEL_READY}, 32'h1);
      chk("rst_mid_cur0", {30'd0, CUR_SRC}, 32'h0);
      $display("reset recovery complete at cycle %0d, SRC_EN=%b", cyc, SRC_EN);

      at_cyc(cyc + 4);
      chk("done_queue_empty", exp_q.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/clock_switch_ctrl.md
# clock_switch_ctrl

Single-clock sequencer for an N-way glitch-free clock switch. It accepts a source-select request, runs a break-before-make sequence over the per-source gate enables, and reports completion. Gate status is synchronised in, and bounded timeouts handle dead sources. It sits in the always-on control domain and drives the enable inputs of the per-source clock gating cells that feed the USB core clock tree. It generalises the two-input cross-coupled mux to NUM_SRC sources with explicit dead time and error reporting.

## Interface
Parameters:
- NUM_SRC, 4: number of clock sources (≥2).
- SEL_W, $clog2(NUM_SRC): width of source index.
- DEAD_CYCLES, 4: CLK cycles with all enables low between break and make (≥1).
- ACK_TIMEOUT, 255: max CLK cycles waiting for a gate acknowledge (≥4).
- DEFAULT_SRC, 0: source enabled after reset.

Ports:
- CLK  in  1  control clock; the only clock of this block.
- RST  in  1  synchronous, active-high reset.
- SEL_REQ  in  1  request valid.
- SEL_IDX  in  SEL_W  requested source.
- SEL_READY  out  1  request accepted when SEL_REQ && SEL_READY.
- SRC_EN  out  NUM_SRC  registered one-hot-or-zero gate enables.
- SRC_ACK_ASYNC  in  NUM_SRC  gate-is-running status from each source domain (asynchronous).
- CUR_SRC  out  SEL_W  currently selected source.
- DONE  out  1  one-cycle pulse when a sequence completes.
- ERR_TIMEOUT  out  1  sticky: an acknowledge timed out.
- ERR_BADIDX  out  1  sticky: request with SEL_IDX ≥ NUM_SRC.
- ERR_CLR  in  1  clears both sticky errors.

## Operation
- SRC_ACK_ASYNC passes through a 2-flop synchroniser → ack_s. All decisions use ack_s only.
- States: IDLE, DISABLE, DEAD, ENABLE.
- IDLE:
  - SEL_READY=1.
  - On accept with SEL_IDX ≥ NUM_SRC: set ERR_BADIDX and stay IDLE.
  - On accept with SEL_IDX == CUR_SRC: pulse DONE next cycle and stay IDLE. No enable change.
  - Otherwise latch target, clear SRC_EN and go to DISABLE.
- DISABLE:
  - Wait for ack_s[CUR_SRC]==0, then go to DEAD.
  - After ACK_TIMEOUT cycles: set ERR_TIMEOUT and go to DEAD anyway. A stopped old source must not block the switch.
- DEAD: count DEAD_CYCLES cycles with SRC_EN=0, then set SRC_EN[target] and go to ENABLE.
- ENABLE:
  - Wait for ack_s[target]==1, then CUR_SRC←target, pulse DONE and go to IDLE.
  - After ACK_TIMEOUT cycles: set ERR_TIMEOUT, keep SRC_EN[target]=1, CUR_SRC←target, pulse DONE and go to IDLE.
- SRC_EN never has more than one bit set. It changes only on state entry.
- SEL_REQ outside IDLE is ignored (SEL_READY=0). Requests are not queued.
- ERR_CLR:
  - Clears both sticky flags.
  - If a set event happens in the same cycle, the set wins.
- Timeout counter: ACK width = $clog2(ACK_TIMEOUT+1) bits. It reloads on entry to DISABLE and ENABLE and saturates, so it never wraps.

## Timing
- Reset values:
  - State DEAD, target=DEFAULT_SRC, dead counter loaded.
  - SRC_EN=0, CUR_SRC=DEFAULT_SRC, SEL_READY=0, DONE=0, both errors 0.
- After reset, the block runs DEAD → ENABLE on DEFAULT_SRC. There is no DONE pulse for this power-up sequence.
- Accept in cycle n: state=DISABLE and SRC_EN=0 at n+1.
- Minimum switch time with ideal acks: 2 cycles (sync) + DEAD_CYCLES + 2 cycles (sync) + 2 cycles of state overhead. With DEAD_CYCLES=4, DONE asserts at n+10.
- DONE is high for exactly one cycle. SEL_READY rises in the same cycle as DONE.
- RST mid-sequence: immediate return to the reset values. SRC_EN drops at the next edge. The dead time is re-applied before DEFAULT_SRC is enabled.

## Structure
- clock_switch_pkg: state enum type, and the clog2-derived width helper constants.
- Sub-module sync_2ff (parameter WIDTH), used once with WIDTH=NUM_SRC. It is reusable elsewhere in the codebase.
- Top level: FSM, dead counter, timeout counter, error flags.

## Test plan
- Reset, then acks follow enables with 2-cycle delay → SRC_EN=4'b0001 after DEAD_CYCLES; no DONE pulse; SEL_READY=1 in IDLE.
- Request 2 accepted at cycle n, acks follow with 2-cycle delay → SRC_EN=0 for ≥4 cycles, then 4'b0100; DONE at n+10; CUR_SRC=2.
- Request CUR_SRC=1 while source 1 is active → DONE next cycle; SRC_EN unchanged; no DISABLE state entered.
- Old ack stuck high, ACK_TIMEOUT=16 → ERR_TIMEOUT set about 16 cycles after break; switch completes to the new source.
- NUM_SRC=3, SEL_IDX=3 → ERR_BADIDX=1; state stays IDLE; ERR_CLR clears it. ERR_CLR asserted together with a new bad index → flag stays 1.
- RST during ENABLE of source 3 → SRC_EN=0 next cycle, then SRC_EN=4'b0001 after DEAD_CYCLES; CUR_SRC=0.
